// File: rtl/tc_pl_cap_gain_pkg.sv
// -----------------------------------------------------------------------------
// tc_pl_cap_gain_pkg
// Shared definitions for the capture-gain DAC serial-frame receiver:
//   - receiver FSM state encoding
//   - cmd/addr field positions inside a frame (offsets counted down from the MSB)
//   - default channel A/B address-field values
// -----------------------------------------------------------------------------
package tc_pl_cap_gain_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_WAIT_HI = 2'd0,   // wait for CSN high after reset before decoding anything
        ST_IDLE    = 2'd1,   // between frames
        ST_SHIFT   = 2'd2,   // frame in progress, shifting bits in
        ST_CHECK   = 2'd3    // frame ended, judge length and publish
    } rx_state_e;

    // Field layout: cmd is the top nibble, addr the next nibble, data the rest.
    localparam int CMD_W        = 4;
    localparam int ADDR_W       = 4;
    localparam int CMD_MSB_OFS  = 1;   // cmd MSB  = FRAME_W - CMD_MSB_OFS
    localparam int ADDR_MSB_OFS = 5;   // addr MSB = FRAME_W - ADDR_MSB_OFS

    // Default address-field values for the two gain channels
    localparam logic [ADDR_W-1:0] ADDR_A_DEF = 4'b0001;
    localparam logic [ADDR_W-1:0] ADDR_B_DEF = 4'b1000;

endpackage

// File: rtl/tc_pl_sync_edge.sv
// -----------------------------------------------------------------------------
// tc_pl_sync_edge
// Brings one asynchronous pin into the clk domain through a SYNC_STAGES flop
// chain and detects edges by comparing the last stage against one more register.
//
// Ports:
//   clk   in  : system clock
//   rst   in  : asynchronous active-low reset
//   d     in  : asynchronous input pin
//   lvl   out : synchronized level
//   rise  out : one-cycle pulse on a synchronized 0->1 transition
//   fall  out : one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module tc_pl_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain plus the edge-detect history register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_r[SYNC_STAGES-1];
    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/tc_pl_cap_gain_dac_rx.sv
// -----------------------------------------------------------------------------
// tc_pl_cap_gain_dac_rx
// Loopback/readback receiver for the capture-gain DAC serial link. Snoops the
// DAC0_SCK/DAC0_CSN/DAC0_SDI lines, deserializes each chip-select frame (MSB
// first), checks that exactly FRAME_W bits were clocked, and latches good
// frames addressed to channel A or B so the PL can compare them against the
// gain values it programmed.
//
// Ports:
//   clk       in          : system clock
//   rst       in          : asynchronous active-low reset
//   DAC0_SCK  in          : serial clock (asynchronous to clk)
//   DAC0_CSN  in          : frame select, active-low
//   DAC0_SDI  in          : serial data, MSB first
//   rx_word   out FRAME_W : last good frame
//   rx_valid  out         : one-cycle pulse when rx_word is updated
//   rx_err    out         : one-cycle pulse when a frame had the wrong length
//   rd_dacA   out FRAME_W : last good frame addressed to ADDR_A
//   rd_dacB   out FRAME_W : last good frame addressed to ADDR_B
//   rx_busy   out         : frame in progress (SHIFT or CHECK)
//   good_cnt  out CNT_W   : good-frame count, saturating
//   err_cnt   out CNT_W   : errored-frame count, saturating
// -----------------------------------------------------------------------------
module tc_pl_cap_gain_dac_rx
    import tc_pl_cap_gain_pkg::*;
#(
    parameter int                FRAME_W     = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] ADDR_A      = ADDR_A_DEF,
    parameter logic [ADDR_W-1:0] ADDR_B      = ADDR_B_DEF,
    parameter int                CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               DAC0_SCK,
    input  logic               DAC0_CSN,
    input  logic               DAC0_SDI,
    output logic [FRAME_W-1:0] rx_word,
    output logic               rx_valid,
    output logic               rx_err,
    output logic [FRAME_W-1:0] rd_dacA,
    output logic [FRAME_W-1:0] rd_dacB,
    output logic               rx_busy,
    output logic [CNT_W-1:0]   good_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    // One extra bit so the counter can reach FRAME_W itself
    localparam int                  BIT_CNT_W = $clog2(FRAME_W) + 1;
    localparam logic [BIT_CNT_W-1:0] FRAME_LEN = BIT_CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

    // Synchronized pin views
    logic sck_rise_s;
    logic sck_lvl_unused_s;
    logic sck_fall_unused_s;
    logic csn_lvl_s;
    logic csn_rise_s;
    logic csn_fall_s;
    logic sdi_lvl_s;
    logic sdi_rise_unused_s;
    logic sdi_fall_unused_s;

    // FSM and datapath
    rx_state_e             state_r;
    rx_state_e             state_next_s;
    logic [FRAME_W-1:0]    shift_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic                  ovf_r;
    logic                  frame_start_s;
    logic                  shift_en_s;
    logic                  frame_good_s;
    logic [ADDR_W-1:0]     addr_s;

    // Registered outputs
    logic [FRAME_W-1:0]    rx_word_r;
    logic                  rx_valid_r;
    logic                  rx_err_r;
    logic [FRAME_W-1:0]    rd_dac_a_r;
    logic [FRAME_W-1:0]    rd_dac_b_r;
    logic                  rx_busy_r;
    logic [CNT_W-1:0]      good_cnt_r;
    logic [CNT_W-1:0]      err_cnt_r;

    tc_pl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .d    (DAC0_SCK),
        .lvl  (sck_lvl_unused_s),
        .rise (sck_rise_s),
        .fall (sck_fall_unused_s)
    );

    tc_pl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk  (clk),
        .rst  (rst),
        .d    (DAC0_CSN),
        .lvl  (csn_lvl_s),
        .rise (csn_rise_s),
        .fall (csn_fall_s)
    );

    // SDI shares the SCK synchronizer depth so data and clock stay aligned
    tc_pl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk  (clk),
        .rst  (rst),
        .d    (DAC0_SDI),
        .lvl  (sdi_lvl_s),
        .rise (sdi_rise_unused_s),
        .fall (sdi_fall_unused_s)
    );

    // IDLE is only ever entered with CSN high, so a low synchronized level in
    // IDLE means a fall happened. This also catches a fall that landed while
    // the FSM was still in CHECK and whose edge pulse has already gone.
    assign frame_start_s = csn_fall_s | ~csn_lvl_s;

    // A CSN rise in the same cycle as an SCK rise ends the frame; the SCK
    // edge is dropped.
    assign shift_en_s   = (state_r == ST_SHIFT) & sck_rise_s & ~csn_rise_s;
    assign frame_good_s = (bit_cnt_r == FRAME_LEN) & ~ovf_r;
    assign addr_s       = shift_r[FRAME_W-ADDR_MSB_OFS -: ADDR_W];

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_WAIT_HI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT_HI: begin
                if (csn_lvl_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HI;
                end
            end
            ST_IDLE: begin
                // CSN rises seen here are glitches and are ignored
                if (frame_start_s) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (csn_rise_s) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_WAIT_HI;
            end
        endcase
    end

    // Shift register, bit counter and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r   <= {FRAME_W{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start_s) begin
                        shift_r   <= {FRAME_W{1'b0}};
                        bit_cnt_r <= {BIT_CNT_W{1'b0}};
                        ovf_r     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_en_s) begin
                        shift_r <= {shift_r[FRAME_W-2:0], sdi_lvl_s};
                        // Counter parks at FRAME_W; any further bit is an overrun
                        if (bit_cnt_r == FRAME_LEN) begin
                            ovf_r <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    shift_r   <= shift_r;
                    bit_cnt_r <= bit_cnt_r;
                    ovf_r     <= ovf_r;
                end
            endcase
        end
    end

    // Frame verdict: publish good frames, count both outcomes, pulse flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_word_r  <= {FRAME_W{1'b0}};
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            rd_dac_a_r <= {FRAME_W{1'b0}};
            rd_dac_b_r <= {FRAME_W{1'b0}};
            good_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            if (state_r == ST_CHECK) begin
                if (frame_good_s) begin
                    rx_word_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                    if (good_cnt_r != CNT_MAX) begin
                        good_cnt_r <= good_cnt_r + CNT_W'(1);
                    end
                    if (addr_s == ADDR_A) begin
                        rd_dac_a_r <= shift_r;
                    end else if (addr_s == ADDR_B) begin
                        rd_dac_b_r <= shift_r;
                    end else begin
                        rd_dac_a_r <= rd_dac_a_r;
                    end
                end else begin
                    rx_err_r <= 1'b1;
                    if (err_cnt_r != CNT_MAX) begin
                        err_cnt_r <= err_cnt_r + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Busy follows the state the FSM is about to be in, so it lines up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_busy_r <= 1'b0;
        end else begin
            rx_busy_r <= (state_next_s == ST_SHIFT) || (state_next_s == ST_CHECK);
        end
    end

    assign rx_word  = rx_word_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;
    assign rd_dacA  = rd_dac_a_r;
    assign rd_dacB  = rd_dac_b_r;
    assign rx_busy  = rx_busy_r;
    assign good_cnt = good_cnt_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_tc_pl_cap_gain_dac_rx.sv
// -----------------------------------------------------------------------------
// tb_tc_pl_cap_gain_dac_rx
// Directed self-checking bench for tc_pl_cap_gain_dac_rx. The counters are
// built 4 bits wide so saturation is reachable with a handful of frames.
// -----------------------------------------------------------------------------
module tb_tc_pl_cap_gain_dac_rx;

    localparam int FRAME_W = 32;
    localparam int CNT_W   = 4;
    localparam int LAT     = 4;   // SYNC_STAGES + 2 with the default depth of 2

    logic               clk;
    logic               rst;
    logic               dac_sck;
    logic               dac_csn;
    logic               dac_sdi;
    logic [FRAME_W-1:0] rx_word;
    logic               rx_valid;
    logic               rx_err;
    logic [FRAME_W-1:0] rd_dacA;
    logic [FRAME_W-1:0] rd_dacB;
    logic               rx_busy;
    logic [CNT_W-1:0]   good_cnt;
    logic [CNT_W-1:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    tc_pl_cap_gain_dac_rx #(
        .FRAME_W     (FRAME_W),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DAC0_SCK (dac_sck),
        .DAC0_CSN (dac_csn),
        .DAC0_SDI (dac_sdi),
        .rx_word  (rx_word),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rd_dacA  (rd_dacA),
        .rd_dacB  (rd_dacB),
        .rx_busy  (rx_busy),
        .good_cnt (good_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every drive and sample happens 1 ns after a rising clk edge
    task automatic wait_clks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csn_low();
        wait_clks(6);
        dac_csn = 1'b0;
    endtask

    task automatic csn_high();
        wait_clks(4);
        dac_csn = 1'b1;
    endtask

    // MSB first; SCK high and low phases are 4 clk each
    task automatic send_bits(input logic [63:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            dac_sdi = data[i];
            wait_clks(4);
            dac_sck = 1'b1;
            wait_clks(4);
            dac_sck = 1'b0;
        end
    endtask

    // Watch 8 cycles after CSN rise; report first pulse cycle and pulse width
    task automatic wait_pulse(output int first, output int hits,
                              output logic v, output logic e);
        first = 0;
        hits  = 0;
        v     = 1'b0;
        e     = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            if (rx_valid || rx_err) begin
                hits++;
                if (first == 0) begin
                    first = j;
                    v     = rx_valid;
                    e     = rx_err;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits,
                              output int first, output int hits,
                              output logic v, output logic e);
        csn_low();
        send_bits(data, nbits);
        csn_high();
        wait_pulse(first, hits, v, e);
    endtask

    task automatic test_reset();
        int first, hits;
        logic v, e;
        rst     = 1'b0;
        dac_sck = 1'b0;
        dac_csn = 1'b0;
        dac_sdi = 1'b0;
        wait_clks(3);
        checks++;
        if ({rx_word, rd_dacA, rd_dacB, good_cnt, err_cnt, rx_valid, rx_err, rx_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got word=%h a=%h b=%h g=%0d e=%0d v=%b er=%b busy=%b, want all 0",
                     rx_word, rd_dacA, rd_dacB, good_cnt, err_cnt, rx_valid, rx_err, rx_busy);
        end
        rst = 1'b1;
        wait_clks(2);
        // Frame already in progress at reset release must not decode
        send_bits(64'h5, 3);
        csn_high();
        wait_pulse(first, hits, v, e);
        checks++;
        if (hits !== 0) begin
            errors++;
            $display("FAIL reset_inflight_pulse: got %0d pulse cycles, want 0", hits);
        end
        checks++;
        if (good_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_inflight_cnt: got good=%0d err=%0d, want 0/0", good_cnt, err_cnt);
        end
    endtask

    task automatic test_chan_a();
        int first, hits;
        logic v, e;
        csn_low();
        send_bits(64'h3100_8000, 32);
        csn_high();
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL chan_a_busy: got %b, want 1", rx_busy);
        end
        wait_pulse(first, hits, v, e);
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL chan_a_latency: got %0d, want %0d", first, LAT);
        end
        checks++;
        if (hits !== 1 || v !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL chan_a_pulse: got hits=%0d v=%b e=%b, want 1/1/0", hits, v, e);
        end
        checks++;
        if (rx_word !== 32'h3100_8000 || rd_dacA !== 32'h3100_8000 || rd_dacB !== 32'h0) begin
            errors++;
            $display("FAIL chan_a_data: got word=%h a=%h b=%h, want 31008000/31008000/00000000",
                     rx_word, rd_dacA, rd_dacB);
        end
        checks++;
        if (good_cnt !== 4'd1 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL chan_a_cnt: got good=%0d busy=%b, want 1/0", good_cnt, rx_busy);
        end
    endtask

    task automatic test_chan_b();
        int first, hits;
        logic v, e;
        send_frame(64'h3800_4000, 32, first, hits, v, e);
        checks++;
        if (first !== LAT || hits !== 1 || v !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL chan_b_pulse: got first=%0d hits=%0d v=%b e=%b, want %0d/1/1/0",
                     first, hits, v, e, LAT);
        end
        checks++;
        if (rd_dacB !== 32'h3800_4000 || rd_dacA !== 32'h3100_8000 || rx_word !== 32'h3800_4000) begin
            errors++;
            $display("FAIL chan_b_data: got a=%h b=%h word=%h, want 31008000/38004000/38004000",
                     rd_dacA, rd_dacB, rx_word);
        end
        checks++;
        if (good_cnt !== 4'd2) begin
            errors++;
            $display("FAIL chan_b_cnt: got %0d, want 2", good_cnt);
        end
    endtask

    task automatic test_bad_length();
        int first, hits;
        logic v, e;
        send_frame(64'h1234_5678, 31, first, hits, v, e);
        checks++;
        if (first !== LAT || hits !== 1 || v !== 1'b0 || e !== 1'b1) begin
            errors++;
            $display("FAIL short_frame: got first=%0d hits=%0d v=%b e=%b, want %0d/1/0/1",
                     first, hits, v, e, LAT);
        end
        send_frame(64'h1_1800_BEEF, 33, first, hits, v, e);
        checks++;
        if (first !== LAT || hits !== 1 || v !== 1'b0 || e !== 1'b1) begin
            errors++;
            $display("FAIL long_frame: got first=%0d hits=%0d v=%b e=%b, want %0d/1/0/1",
                     first, hits, v, e, LAT);
        end
        checks++;
        if (err_cnt !== 4'd2 || good_cnt !== 4'd2) begin
            errors++;
            $display("FAIL bad_len_cnt: got err=%0d good=%0d, want 2/2", err_cnt, good_cnt);
        end
        checks++;
        if (rx_word !== 32'h3800_4000 || rd_dacA !== 32'h3100_8000 || rd_dacB !== 32'h3800_4000) begin
            errors++;
            $display("FAIL bad_len_hold: got word=%h a=%h b=%h, want 38004000/31008000/38004000",
                     rx_word, rd_dacA, rd_dacB);
        end
    endtask

    task automatic test_coincident_and_other_addr();
        int first, hits;
        logic v, e;
        csn_low();
        send_bits(64'h2123_4567, 32);
        wait_clks(4);
        // 33rd SCK rise lands together with the CSN rise
        dac_sdi = 1'b1;
        dac_sck = 1'b1;
        dac_csn = 1'b1;
        wait_pulse(first, hits, v, e);
        dac_sck = 1'b0;
        checks++;
        if (first !== LAT || v !== 1'b1 || e !== 1'b0) begin
            errors++;
            $display("FAIL coincident_pulse: got first=%0d v=%b e=%b, want %0d/1/0", first, v, e, LAT);
        end
        checks++;
        if (rd_dacA !== 32'h2123_4567 || good_cnt !== 4'd3) begin
            errors++;
            $display("FAIL coincident_data: got a=%h good=%0d, want 21234567/3", rd_dacA, good_cnt);
        end
        // Address 5 is neither channel
        send_frame(64'h45AB_CDEF, 32, first, hits, v, e);
        checks++;
        if (v !== 1'b1 || rx_word !== 32'h45AB_CDEF || rd_dacA !== 32'h2123_4567 ||
            rd_dacB !== 32'h3800_4000) begin
            errors++;
            $display("FAIL other_addr: got v=%b word=%h a=%h b=%h, want 1/45abcdef/21234567/38004000",
                     v, rx_word, rd_dacA, rd_dacB);
        end
    endtask

    task automatic test_saturation();
        int first, hits;
        logic v, e;
        // good_cnt is 4 here; 11 more reach 15, then 3 beyond the top
        for (int n = 0; n < 11; n++) begin
            send_frame(64'h3F00_0000 + 64'(n), 32, first, hits, v, e);
        end
        checks++;
        if (good_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach: got %0d, want 15", good_cnt);
        end
        for (int n = 0; n < 3; n++) begin
            send_frame(64'h3F00_0100 + 64'(n), 32, first, hits, v, e);
        end
        checks++;
        if (good_cnt !== 4'd15 || rx_word !== 32'h3F00_0102) begin
            errors++;
            $display("FAIL sat_hold: got good=%0d word=%h, want 15/3f000102", good_cnt, rx_word);
        end
    endtask

    task automatic test_reset_mid_frame();
        int first, hits;
        logic v, e;
        csn_low();
        send_bits(64'h3A5, 10);
        rst = 1'b0;
        wait_clks(2);
        checks++;
        if ({rx_word, rd_dacA, rd_dacB, good_cnt, err_cnt, rx_valid, rx_err, rx_busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got word=%h a=%h b=%h g=%0d e=%0d busy=%b, want all 0",
                     rx_word, rd_dacA, rd_dacB, good_cnt, err_cnt, rx_busy);
        end
        rst = 1'b1;
        send_bits(64'h1F, 5);
        csn_high();
        wait_pulse(first, hits, v, e);
        checks++;
        if (hits !== 0 || good_cnt !== 4'd0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_nopulse: got hits=%0d good=%0d err=%0d, want 0/0/0",
                     hits, good_cnt, err_cnt);
        end
        send_frame(64'h3800_1111, 32, first, hits, v, e);
        checks++;
        if (v !== 1'b1 || rd_dacB !== 32'h3800_1111 || rd_dacA !== 32'h0 || good_cnt !== 4'd1) begin
            errors++;
            $display("FAIL midreset_recover: got v=%b a=%h b=%h good=%0d, want 1/00000000/38001111/1",
                     v, rd_dacA, rd_dacB, good_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_chan_a();
        test_chan_b();
        test_bad_length();
        test_coincident_and_other_addr();
        test_saturation();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
